// File: rtl/adder_share_arb_if.sv
// Bundle of the requester, shared-adder and response signals of adder_share_arb.
// The slave modport is the arbiter's view; master is the client/adder side.
interface adder_share_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [OP_W-1:0]         add_a;
  logic [OP_W-1:0]         add_b;
  logic [RES_W-1:0]        add_c;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [RES_W-1:0]        rsp_data;
  logic                    rsp_ready;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, add_c, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, add_c, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer sharing one registered adder between NUM_REQ
// requesters. One operation in flight: grant, wait ADD_LAT cycles for the
// adder, then hold the tagged sum on the response channel until accepted.
module adder_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_share_arb_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic             grant_any;
  logic [IDX_W-1:0] grant_sel;
  logic [IDX_W-1:0] scan_idx;
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;

  // Find the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_sel = scan_idx;
      end
    end
  end

  // Select the granted requester's operands from the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_sel) begin
        sel_a = bus.req_a[i*OP_W +: OP_W];
        sel_b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic plus the combinational grant and busy outputs.
  // A grant only goes to a requester whose valid is high, so in IDLE the
  // handshake happens exactly when any requester is valid.
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (grant_any) begin
          bus.req_ready[grant_sel] = 1'b1;
          state_nx                 = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand, latency-counter, response and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      cnt           <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_any) begin
            bus.add_a  <= sel_a;
            bus.add_b  <= sel_b;
            bus.rsp_id <= ID_W'(grant_sel);
            cnt        <= CNT_W'(ADD_LAT);
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.rsp_data  <= bus.add_c;
            bus.rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= (bus.rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb with a behavioural one-cycle adder.
module tb_adder_share_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned RES_W   = 8;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  adder_share_arb_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .RES_W(RES_W), .ID_W(ID_W)) bus ();

  adder_share_arb #(
    .NUM_REQ(NUM_REQ), .OP_W(OP_W), .RES_W(RES_W), .ADD_LAT(ADD_LAT), .ID_W(ID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared registered adder.
  always @(posedge clk) bus.add_c <= RES_W'(bus.add_a) + RES_W'(bus.add_b);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    bus.req_a[i*OP_W +: OP_W] = a;
    bus.req_b[i*OP_W +: OP_W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for any req_ready bit, then steps past the accept edge.
  task automatic wait_grant(output int g, output bit ok);
    g = -1;
    ok = 1'b0;
    #1;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.req_ready != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g = i;
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.rsp_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); end
    tests_run++; if (bus.add_a !== 4'h0 || bus.add_b !== 4'h0) begin tests_failed++; $display("FAIL reset_add: got a=%0h b=%0h expected 0 0", bus.add_a, bus.add_b); end
    tests_run++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp: got id=%0d data=%0h expected 0 00", bus.rsp_id, bus.rsp_data); end
    tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    tick();
    set_op(2, 4'h3, 4'h5);
    bus.req_valid = 4'b0100;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
    sb.push_back('{2'd2, 8'h08});
    tick();
    bus.req_valid = '0;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_ready_wait: got %b expected 0000", bus.req_ready); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %0b expected 1", bus.busy); end
    tests_run++; if (bus.add_a !== 4'h3 || bus.add_b !== 4'h5) begin tests_failed++; $display("FAIL single_operands: got a=%0h b=%0h expected 3 5", bus.add_a, bus.add_b); end
    tick();
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_rsp: got %0b expected 0", bus.rsp_valid); end
    tick();
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got %0b expected 1", bus.rsp_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++; if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL single_rsp: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
    tests_run++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL single_release: got valid=%0b busy=%0b expected 0 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int g;
    int prev_cyc;
    bit ok;
    exp_t e;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, OP_W'(i), 4'h1);
    bus.req_valid = '1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      tests_run++; if (!ok || g !== exp_order[k]) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, g, exp_order[k]); end
      if (k > 0) begin
        tests_run++; if (cyc - prev_cyc !== ADD_LAT + 3) begin tests_failed++; $display("FAIL rr_period[%0d]: got %0d expected %0d", k, cyc - prev_cyc, ADD_LAT + 3); end
      end
      prev_cyc = cyc;
      sb.push_back('{ID_W'(exp_order[k]), RES_W'(exp_order[k] + 1)});
      wait_rsp(ok);
      tests_run++;
      if (!ok || sb.size() == 0) begin
        tests_failed++; $display("FAIL rr_rsp_timeout[%0d]: got no response expected one", k);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL rr_rsp[%0d]: got id=%0d data=%0h expected id=%0d data=%0h", k, bus.rsp_id, bus.rsp_data, e.id, e.data); end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_width();
    int g;
    bit ok;
    exp_t e;
    set_op(1, 4'hF, 4'hF);
    bus.req_valid = 4'b0010;
    sb.push_back('{2'd1, 8'h1E});
    wait_grant(g, ok);
    bus.req_valid = '0;
    tests_run++; if (!ok || g !== 1) begin tests_failed++; $display("FAIL width_grant: got %0d expected 1", g); end
    wait_rsp(ok);
    tests_run++;
    if (!ok || sb.size() == 0) begin
      tests_failed++; $display("FAIL width_timeout: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL width_rsp: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int g;
    bit ok;
    exp_t e;
    bus.rsp_ready = 1'b0;
    set_op(0, 4'h7, 4'h2);
    set_op(1, 4'h4, 4'h4);
    bus.req_valid = 4'b0001;
    sb.push_back('{2'd0, 8'h09});
    wait_grant(g, ok);
    bus.req_valid = 4'b1110;
    #1;
    tests_run++; if (!ok || g !== 0) begin tests_failed++; $display("FAIL bp_grant: got %0d expected 0", g); end
    tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready_wait: got %b expected 0000", bus.req_ready); end
    wait_rsp(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_timeout: got no response expected one"); end
    for (int n = 0; n < 5; n++) begin
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h09 || bus.req_ready !== 4'b0000) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got valid=%0b id=%0d data=%0h ready=%b expected 1 0 09 0000", n, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready);
      end
      tick();
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++; if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL bp_rsp: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    bus.rsp_ready = 1'b1;
    tick();
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got %0b expected 0", bus.rsp_valid); end
    tests_run++; if (bus.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_next_grant: got %b expected 0010", bus.req_ready); end
    sb.push_back('{2'd1, 8'h08});
    wait_grant(g, ok);
    bus.req_valid = '0;
    tests_run++; if (!ok || g !== 1) begin tests_failed++; $display("FAIL bp_grant2: got %0d expected 1", g); end
    wait_rsp(ok);
    tests_run++;
    if (!ok || sb.size() == 0) begin
      tests_failed++; $display("FAIL bp_timeout2: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL bp_rsp2: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int g;
    bit ok;
    exp_t e;
    set_op(2, 4'h9, 4'h9);
    bus.req_valid = 4'b0100;
    wait_grant(g, ok);
    bus.req_valid = '0;
    tests_run++; if (!ok || g !== 2) begin tests_failed++; $display("FAIL rw_grant: got %0d expected 2", g); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_state: got busy=%0b valid=%0b expected 0 0", bus.busy, bus.rsp_valid); end
    tests_run++; if (bus.add_a !== 4'h0 || bus.add_b !== 4'h0) begin tests_failed++; $display("FAIL rw_add: got a=%0h b=%0h expected 0 0", bus.add_a, bus.add_b); end
    set_op(1, 4'h2, 4'h3);
    set_op(3, 4'h4, 4'h4);
    bus.req_valid = 4'b1010;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rw_ptr_reset: got %b expected 0010", bus.req_ready); end
    sb.push_back('{2'd1, 8'h05});
    wait_grant(g, ok);
    bus.req_valid = '0;
    wait_rsp(ok);
    tests_run++;
    if (!ok || sb.size() == 0) begin
      tests_failed++; $display("FAIL rw_timeout: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL rw_rsp: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
  endtask

  task automatic test_wrap();
    int g;
    bit ok;
    exp_t e;
    set_op(3, 4'h1, 4'h2);
    bus.req_valid = 4'b1000;
    sb.push_back('{2'd3, 8'h03});
    wait_grant(g, ok);
    bus.req_valid = '0;
    tests_run++; if (!ok || g !== 3) begin tests_failed++; $display("FAIL wrap_grant3: got %0d expected 3", g); end
    wait_rsp(ok);
    tests_run++;
    if (!ok || sb.size() == 0) begin
      tests_failed++; $display("FAIL wrap_timeout: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL wrap_rsp3: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
    set_op(0, 4'h5, 4'h6);
    bus.req_valid = 4'b1001;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL wrap_ready: got %b expected 0001", bus.req_ready); end
    sb.push_back('{2'd0, 8'h0B});
    wait_grant(g, ok);
    bus.req_valid = '0;
    wait_rsp(ok);
    tests_run++;
    if (!ok || sb.size() == 0) begin
      tests_failed++; $display("FAIL wrap_timeout0: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin tests_failed++; $display("FAIL wrap_rsp0: got id=%0d data=%0h expected id=%0d data=%0h", bus.rsp_id, bus.rsp_data, e.id, e.data); end
    end
    tick();
  endtask

  task automatic test_drop();
    set_op(2, 4'h1, 4'h1);
    bus.req_valid = 4'b0100;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL drop_ready: got %b expected 0100", bus.req_ready); end
    bus.req_valid = '0;
    tick();
    tests_run++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL drop_idle: got busy=%0b ready=%b expected 0 0000", bus.busy, bus.req_ready); end
    tick();
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_no_rsp: got %0b expected 0", bus.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_width();
    test_backpressure();
    test_reset_in_wait();
    test_wrap();
    test_drop();
    tests_run++; if (sb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered adder (4-bit operands, 8-bit registered sum, one-cycle latency) between NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready handshakes and drives the shared adder's operand inputs.
- Waits the adder latency, then returns the sum tagged with the requester index on a single response channel.
- Sits between client blocks and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- OP_W, 4, operand width
- RES_W, 8, result width (≥ OP_W+1)
- ADD_LAT, 1, adder latency in clk cycles from operand change to valid c (1..4)
- ID_W, 2, width of rsp_id (≥ clog2(NUM_REQ))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*OP_W  packed operand A, requester i at [i*OP_W +: OP_W]
- req_b  in  NUM_REQ*OP_W  packed operand B, same packing
- add_a  out  OP_W  operand A to shared adder, registered
- add_b  out  OP_W  operand B to shared adder, registered
- add_c  in  RES_W  registered sum from shared adder
- rsp_valid  out  1  response valid
- rsp_id  out  ID_W  index of requester owning the response
- rsp_data  out  RES_W  captured sum
- rsp_ready  in  1  response consumer accept
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Sampled only on the clk rising edge while rst_n=0.
  - State goes to IDLE; rr_ptr=0; wait counter=0.
  - add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready is combinational and is 0 whenever the state is not IDLE.
- States: IDLE, WAIT, RESP. Exactly one operation is in flight at a time.
- IDLE:
  - g = first index with req_valid=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other bits are 0; all bits are 0 if no req_valid is set.
  - On the edge where req_valid[g] && req_ready[g]: add_a<=req_a[g], add_b<=req_b[g], rsp_id<=g, cnt<=ADD_LAT, state<=WAIT.
- WAIT:
  - add_a and add_b are held stable.
  - While cnt≠0, each edge does cnt<=cnt-1.
  - On the edge where cnt==0: rsp_data<=add_c, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On the edge where rsp_valid && rsp_ready: rsp_valid<=0, rr_ptr<=(rsp_id+1) mod NUM_REQ, state<=IDLE.
  - No new grant is issued in that same cycle; the next grant earliest in the following cycle.
- Latency: rsp_valid rises ADD_LAT+1 cycles after the accept edge. With ADD_LAT=1, accept at edge N gives rsp_valid high after edge N+2.
- Throughput: at most one operation per ADD_LAT+3 cycles when rsp_ready is held high.
- Fairness: the requester granted most recently has the lowest priority at the next grant. Any continuously asserted req_valid is granted within NUM_REQ operations.
- Width rule: rsp_data is add_c exactly as produced (zero-extended sum, no saturation). Example: 4'hF+4'hF gives 8'h1E.
- Boundaries:
  - req_valid dropping in the same cycle as its grant: no handshake, stay in IDLE.
  - req_valid asserted during WAIT or RESP: ignored, req_ready=0.
  - Operands of non-granted requesters have no effect.
  - Reset during WAIT or RESP discards the in-flight operation with no response; rr_ptr returns to 0.
  - rr_ptr at NUM_REQ-1 wraps to 0.
  - rsp_ready high while rsp_valid=0: no effect.
- busy=1 in WAIT and RESP.

Test Plan:
- Reset, then only requester 2 valid with a=4'h3, b=4'h5 and rsp_ready=1 → req_ready=4'b0100 for one cycle; rsp_valid high 2 cycles after accept with rsp_id=2, rsp_data=8'h08.
- All four requesters held valid, a=i, b=1 → grant order 0,1,2,3,0; rsp_data sequence 8'h01, 8'h02, 8'h03, 8'h04, 8'h01.
- a=4'hF, b=4'hF → rsp_data=8'h1E.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid, rsp_id and rsp_data stable, req_ready=0; release → rsp_valid falls; next grant starts 1 cycle later.
- rst_n=0 for one edge while in WAIT → next cycle busy=0, rsp_valid=0, add_a=0; request 1 and 3 both valid then → grant 1 first (rr_ptr=0).
- Requester 3 served, then requesters 0 and 3 valid → requester 0 granted (pointer wraps).
